// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, data width and symbol-length helper.
// Optional macro UART_TRANSMITTER_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 8;

`ifdef UART_TRANSMITTER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

  // Clock cycles per line symbol (integer division).
  function automatic int unsigned symbol_cycles(input int unsigned clock_frequency,
                                                input int unsigned baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_symbol_timer.sv
// uart_symbol_timer: 32-bit down-counter timing one UART symbol.
// Loaded with (cycles - 1) at symbol start; done while the count is zero.
module uart_symbol_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        done
);

  logic [31:0] count;

  // Load at symbol start, then count down to zero and hold there.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 32'd1;
    end
  end

  // Symbol ends in the cycle the count sits at zero.
  always_comb begin
    done = (count == '0);
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with valid/ready byte input.
// Define UART_TRANSMITTER_PARITY_EN to insert an even-parity symbol before STOP.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned clock_frequency = 50000000,
  parameter int unsigned baud_rate       = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int unsigned SYMBOL_CYCLES = symbol_cycles(clock_frequency, baud_rate);
  localparam logic [31:0] SYMBOL_LOAD   = 32'(SYMBOL_CYCLES - 1);

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] shift;
  logic [2:0]            bit_count;
  logic                  ready_q;
  logic                  handshake;
  logic                  symbol_load;
  logic                  symbol_done;
`ifdef UART_TRANSMITTER_PARITY_EN
  logic                  parity;
`endif

  // Ready is masked by reset so it drops in reset cycles and rises the first cycle after.
  always_comb begin
    byte_ready  = ready_q & ~reset;
    handshake   = byte_valid & byte_ready;
    symbol_load = handshake | (symbol_done & (state != IDLE) & (state != STOP));
  end

  uart_symbol_timer u_symbol_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (symbol_load),
    .load_value (SYMBOL_LOAD),
    .done       (symbol_done)
  );

  // Frame sequencer: latch on handshake, then START, 8 data bits LSB first, [PARITY], STOP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      ready_q   <= 1'b1;
      shift     <= '0;
      bit_count <= '0;
`ifdef UART_TRANSMITTER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            shift     <= byte_data;
            bit_count <= '0;
            tx        <= 1'b0;
            ready_q   <= 1'b0;
            state     <= START;
`ifdef UART_TRANSMITTER_PARITY_EN
            parity    <= ^byte_data;
`endif
          end
        end
        START: begin
          if (symbol_done) begin
            tx        <= shift[0];
            shift     <= shift >> 1;
            bit_count <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (symbol_done) begin
            if (bit_count == 3'd7) begin
`ifdef UART_TRANSMITTER_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx        <= shift[0];
              shift     <= shift >> 1;
              bit_count <= bit_count + 3'd1;
            end
          end
        end
`ifdef UART_TRANSMITTER_PARITY_EN
        PARITY: begin
          if (symbol_done) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (symbol_done) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          tx      <= 1'b1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Fewer than two cycles per symbol cannot be timed by the down-counter.
  always_ff @(posedge clock) begin
    assert (SYMBOL_CYCLES >= 2)
      else $error("uart_transmitter: clock_frequency/baud_rate must be at least 2");
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: table-driven frame checks plus hand-written corner sequences;
// a line monitor decodes every frame and compares it against a byte scoreboard.
module tb_uart_transmitter;

  localparam int unsigned C = 10;
`ifdef UART_TRANSMITTER_PARITY_EN
  localparam int unsigned NSYM = 11;
`else
  localparam int unsigned NSYM = 10;
`endif
  localparam int unsigned FRAME = NSYM * C;

  logic       clock      = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] byte_data  = '0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       tx;

  int unsigned cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  sb[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         noise;
  } vec_t;

  vec_t vecs[8];

  uart_transmitter #(
    .clock_frequency (10),
    .baud_rate       (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx         (tx)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Leaves the caller 1 time unit after the posedge that starts cycle 'target'.
  task automatic goto_cycle(input int unsigned target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Offer a byte from the next cycle on; returns the handshake cycle in n.
  task automatic send(input logic [7:0] d, output int unsigned n);
    @(posedge clock);
    #1;
    byte_data  = d;
    byte_valid = 1'b1;
    sb.push_back(d);
    #3;
    for (int t = 0; t < 400 && byte_ready !== 1'b1; t++) begin
      @(posedge clock);
      #4;
    end
    check("handshake_seen", byte_ready, 1'b1);
    n = cyc;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input bit noise, input string tag);
    int unsigned n;
    int unsigned busy;
    logic [10:0] exp;
    send(d, n);
    exp  = {1'b1, (NSYM == 11) ? par : 1'b1, d, 1'b0};
    busy = 0;
    for (int unsigned c = n + 1; c <= n + FRAME; c++) begin
      goto_cycle(c);
      if (noise) begin
        byte_valid = 1'($urandom_range(0, 1));
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b0;
      end
      #3;
      if (byte_ready !== 1'b0) busy++;
      if ((c - n - 1) % C == 0) check({tag, "_symbol"}, tx, exp[(c - n - 1) / C]);
    end
    goto_cycle(n + FRAME + 1);
    byte_valid = 1'b0;
    #3;
    check({tag, "_busy_ready"}, busy, 0);
    check({tag, "_ready_return"}, byte_ready, 1'b1);
    check({tag, "_idle_tx"}, tx, 1'b1);
  endtask

  // Line monitor: on a start bit, pop the expected byte and check every cycle of the frame.
  initial begin
    logic [7:0]  e;
    logic [7:0]  rx;
    logic        lv;
    int unsigned errs;
    int unsigned sym;
    bit          abort;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && tx === 1'b0) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
          e = '0;
        end else begin
          e = sb.pop_front();
        end
        errs  = 0;
        abort = 0;
        rx    = '0;
        for (int unsigned t = 0; t < FRAME; t++) begin
          if (t > 0) @(negedge clock);
          if (reset !== 1'b0) begin
            abort = 1;
            break;
          end
          sym = t / C;
          if (sym == 0) lv = 1'b0;
          else if (sym <= 8) lv = e[sym - 1];
          else if (sym == 9 && NSYM == 11) lv = ^e;
          else lv = 1'b1;
          if (tx !== lv) errs++;
          if (sym >= 1 && sym <= 8 && (t % C) == C / 2) rx[sym - 1] = tx;
        end
        if (!abort) begin
          check("frame_wave", errs, 0);
          check("frame_byte", rx, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned busy;

    vecs[0] = '{8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 1'b0};
    vecs[5] = '{8'h03, 1'b0, 1'b0};
    vecs[6] = '{8'h96, 1'b0, 1'b1};
    vecs[7] = '{8'h01, 1'b1, 1'b1};

    // Reset state and release.
    goto_cycle(3);
    #3;
    check("reset_tx", tx, 1'b1);
    check("reset_ready", byte_ready, 1'b0);
    goto_cycle(4);
    reset = 1'b0;
    #3;
    check("reset_release_ready", byte_ready, 1'b1);
    check("reset_release_tx", tx, 1'b1);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].par, vecs[i].noise, $sformatf("vec%0d", i));
    end

    // byte_valid held: 0xA5 then 0x3C back to back with one idle cycle.
    send(8'hA5, n);
    busy = 0;
    for (int unsigned c = n + 1; c <= n + FRAME; c++) begin
      goto_cycle(c);
      if (c == n + 1) begin
        byte_data = 8'h3C;
        sb.push_back(8'h3C);
      end
      #3;
      if (byte_ready !== 1'b0) busy++;
    end
    check("b2b_busy_ready", busy, 0);
    goto_cycle(n + FRAME + 1);
    #3;
    check("b2b_gap_ready", byte_ready, 1'b1);
    check("b2b_gap_tx", tx, 1'b1);
    goto_cycle(n + FRAME + 2);
    byte_valid = 1'b0;
    #3;
    check("b2b_second_start", tx, 1'b0);
    check("b2b_second_busy", byte_ready, 1'b0);
    goto_cycle(n + 2 * FRAME + 2);
    #3;
    check("b2b_second_ready", byte_ready, 1'b1);

    // Reset mid-frame, then a clean frame.
    send(8'hFF, n);
    goto_cycle(n + 1);
    byte_valid = 1'b0;
    goto_cycle(n + 45);
    reset = 1'b1;
    goto_cycle(n + 46);
    #3;
    check("midrst_tx", tx, 1'b1);
    check("midrst_ready", byte_ready, 1'b0);
    goto_cycle(n + 48);
    #3;
    check("midrst_hold_tx", tx, 1'b1);
    goto_cycle(n + 49);
    reset = 1'b0;
    #3;
    check("midrst_release_ready", byte_ready, 1'b1);
    check("midrst_release_tx", tx, 1'b1);
    run_frame(8'h00, 1'b0, 1'b0, "post_rst");

    goto_cycle(cyc + 5);
    #3;
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
